iu_sequencer: RTL

IU_SEQUENCER -- requirements
Module: iu_sequencer

---
 rtl/iu_sequencer_if.sv | 28 ++
 rtl/iu_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iu_sequencer_if.sv
// Byte-read / word-write memory bus between the sequencer and program/result memory.
// One request at a time; mem_resp is a single-cycle completion strobe.
interface iu_sequencer_if;
   logic        read_req;
   logic        write_req;
   logic [13:0] addrout;
   logic [7:0]  datatoinst;
   logic [15:0] datatomem;
   logic        mem_resp;

   modport master (
      output read_req,
      output write_req,
      output addrout,
      output datatomem,
      input  datatoinst,
      input  mem_resp
   );

   modport slave (
      input  read_req,
      input  write_req,
      input  addrout,
      input  datatomem,
      output datatoinst,
      output mem_resp
   );
endinterface

// File: rtl/iu_sequencer.sv
// Instruction sequencer: fetches 3-byte instructions, drives the ALU, stores 16-bit results.
// state     | meaning
// IDLE      | parked; waits for run with halted clear, loads pc and rp
// FETCH_OP  | read opcode byte; halt bit or illegal op ends in HALT
// FETCH_A   | read operand A
// FETCH_B   | read operand B, raise IU_start
// EXEC      | one cycle of IU_start; nop returns to fetch/idle from here
// WAIT_ALU  | hold IU_start and operands until alu_done
// STORE     | write IU_result at rp, then next instruction or IDLE
// HALT      | terminal until reset
module iu_sequencer (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  run,
   input  logic [13:0]           start_addr,
   input  logic [13:0]           res_base,
   iu_sequencer_if.master        mem,
   output logic [7:0]            IU_A,
   output logic [7:0]            IU_B,
   output logic [2:0]            op_set,
   output logic                  IU_start,
   input  logic                  alu_done,
   input  logic [15:0]           alu_result,
   output logic [15:0]           IU_result,
   output logic                  halted,
   output logic                  error
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FETCH_OP = 3'd1;
   localparam logic [2:0] S_FETCH_A  = 3'd2;
   localparam logic [2:0] S_FETCH_B  = 3'd3;
   localparam logic [2:0] S_EXEC     = 3'd4;
   localparam logic [2:0] S_WAIT_ALU = 3'd5;
   localparam logic [2:0] S_STORE    = 3'd6;
   localparam logic [2:0] S_HALT     = 3'd7;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_MUL = 3'b100;

   logic [2:0]  state_q,  state_d;
   logic [13:0] pc_q,     pc_d;
   logic [13:0] rp_q,     rp_d;
   logic [2:0]  op_q,     op_d;
   logic        rd_q,     rd_d;
   logic        wr_q,     wr_d;
   logic [13:0] addr_q,   addr_d;
   logic [15:0] wdata_q,  wdata_d;
   logic [7:0]  a_q,      a_d;
   logic [7:0]  b_q,      b_d;
   logic [2:0]  opset_q,  opset_d;
   logic        start_q,  start_d;
   logic [15:0] result_q, result_d;
   logic        halted_q, halted_d;
   logic        error_q,  error_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rp_d     = rp_q;
      op_d     = op_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      a_d      = a_q;
      b_d      = b_q;
      opset_d  = opset_q;
      start_d  = start_q;
      result_d = result_q;
      halted_d = halted_q;
      error_d  = error_q;

      case (state_q)
         S_IDLE: begin
            if (run && !halted_q) begin
               state_d = S_FETCH_OP;
               pc_d    = start_addr;
               rp_d    = res_base;
            end
         end
         // Each fetch spends one cycle with read_req low before issuing, so the
         // request always drops for a cycle between consecutive bytes.
         S_FETCH_OP, S_FETCH_A, S_FETCH_B: begin
            if (!rd_q) begin
               rd_d   = 1'b1;
               addr_d = pc_q;
            end else if (mem.mem_resp) begin
               rd_d = 1'b0;
               pc_d = pc_q + 14'd1;
               if (state_q == S_FETCH_OP) begin
                  op_d = mem.datatoinst[2:0];
                  if (mem.datatoinst[7]) begin
                     state_d  = S_HALT;
                     halted_d = 1'b1;
                  end else if (mem.datatoinst[2:0] > OP_MUL) begin
                     state_d  = S_HALT;
                     halted_d = 1'b1;
                     error_d  = 1'b1;
                  end else begin
                     state_d = S_FETCH_A;
                  end
               end else if (state_q == S_FETCH_A) begin
                  a_d     = mem.datatoinst;
                  state_d = S_FETCH_B;
               end else begin
                  b_d     = mem.datatoinst;
                  opset_d = op_q;
                  start_d = 1'b1;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            if (op_q == OP_NOP) begin
               start_d = 1'b0;
               state_d = run ? S_FETCH_OP : S_IDLE;
            end else begin
               state_d = S_WAIT_ALU;
            end
         end
         S_WAIT_ALU: begin
            if (alu_done) begin
               result_d = alu_result;
               start_d  = 1'b0;
               state_d  = S_STORE;
            end
         end
         S_STORE: begin
            if (!wr_q) begin
               wr_d    = 1'b1;
               addr_d  = rp_q;
               wdata_d = result_q;
            end else if (mem.mem_resp) begin
               wr_d    = 1'b0;
               rp_d    = rp_q + 14'd1;
               state_d = run ? S_FETCH_OP : S_IDLE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         rp_q     <= '0;
         op_q     <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opset_q  <= '0;
         start_q  <= 1'b0;
         result_q <= '0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rp_q     <= rp_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opset_q  <= opset_d;
         start_q  <= start_d;
         result_q <= result_d;
         halted_q <= halted_d;
         error_q  <= error_d;
      end
   end

   assign mem.read_req  = rd_q;
   assign mem.write_req = wr_q;
   assign mem.addrout   = addr_q;
   assign mem.datatomem = wdata_q;
   assign IU_A          = a_q;
   assign IU_B          = b_q;
   assign op_set        = opset_q;
   assign IU_start      = start_q;
   assign IU_result     = result_q;
   assign halted        = halted_q;
   assign error         = error_q;

endmodule
